// File: rtl/nbit_cpu_pkg.sv
// Shared types for the nbit_cpu slice: opcode encoding and controller states.
// The instruction word is {op[1:0], arg[W-1:0]}.
package nbit_cpu_pkg;

  typedef enum logic [1:0] {
    OP_XOR = 2'b00,
    OP_LD  = 2'b01,
    OP_JMP = 2'b10,
    OP_JZ  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_HALT  = 2'b11
  } state_e;

  localparam int W_MIN = 2;
  localparam int W_MAX = 16;

endpackage

// File: rtl/nbit_alu.sv
// Combinational next-state datapath: computes the register and pc values an
// instruction produces, and flags jumps that target their own address.
module nbit_alu
  import nbit_cpu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] reg_in,
  input  logic [W-1:0] pc_in,
  input  op_e          op,
  input  logic [W-1:0] arg,
  output logic [W-1:0] reg_next,
  output logic [W-1:0] pc_next,
  output logic         self_loop
);

  logic [W-1:0] pc_inc;

  // Increment wraps naturally at 2^W.
  assign pc_inc = pc_in + {{(W-1){1'b0}}, 1'b1};

  always_comb begin
    reg_next  = reg_in;
    pc_next   = pc_inc;
    self_loop = 1'b0;
    case (op)
      OP_XOR: reg_next = reg_in ^ arg;
      OP_LD:  reg_next = arg;
      OP_JMP: begin
        pc_next   = arg;
        self_loop = (arg == pc_in);
      end
      OP_JZ: begin
        if (reg_in == '0) begin
          pc_next   = arg;
          self_loop = (arg == pc_in);
        end
      end
      default: begin
        reg_next  = reg_in;
        pc_next   = pc_inc;
        self_loop = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/nbit_cpu.sv
// Tiny accumulator CPU: IDLE/FETCH/EXEC/HALT controller with an instruction
// fetch handshake; status outputs come straight from flops.
module nbit_cpu
  import nbit_cpu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [W+1:0] imem_data,
  output logic [W-1:0] reg_out,
  output logic [W-1:0] pc_out,
  output logic         busy,
  output logic         halted
);

  state_e       state_q, state_d;
  logic [W-1:0] reg_q, reg_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W+1:0] ir_q, ir_d;
  logic         imem_req_q, busy_q, halted_q;

  logic [W-1:0] alu_reg, alu_pc;
  logic         alu_self_loop;

  nbit_alu #(.W(W)) u_alu (
    .reg_in    (reg_q),
    .pc_in     (pc_q),
    .op        (op_e'(ir_q[W+1:W])),
    .arg       (ir_q[W-1:0]),
    .reg_next  (alu_reg),
    .pc_next   (alu_pc),
    .self_loop (alu_self_loop)
  );

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        reg_d   = alu_reg;
        pc_d    = alu_pc;
        state_d = alu_self_loop ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      reg_q      <= '0;
      pc_q       <= '0;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_q      <= reg_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      imem_req_q <= (state_d == S_FETCH);
      busy_q     <= (state_d == S_FETCH) || (state_d == S_EXEC);
      halted_q   <= (state_d == S_HALT);
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign reg_out   = reg_q;
  assign pc_out    = pc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule

// File: doc/nbit_cpu.md
NBIT_CPU -- requirements
Module: nbit_cpu

Interface
REQ-001 Parameter: W, default 4, data-register width and program-counter width; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  one-cycle pulse; begins execution from IDLE or HALT.
REQ-005 Port: imem_req  output  1  instruction fetch request.
REQ-006 Port: imem_addr  output  W  fetch address, equals pc_out.
REQ-007 Port: imem_ack  input  1  fetch acknowledge; imem_data valid in the same cycle.
REQ-008 Port: imem_data  input  W+2  instruction {op[1:0], arg[W-1:0]}.
REQ-009 Port: reg_out  output  W  data register.
REQ-010 Port: pc_out  output  W  program counter.
REQ-011 Port: busy  output  1  high in FETCH or EXEC.
REQ-012 Port: halted  output  1  high in HALT.

Function
REQ-013 FSM states: IDLE, FETCH, EXEC, HALT.
REQ-014 IDLE: start=1 -> FETCH next cycle; otherwise remain.
REQ-015 FETCH: imem_req=1, imem_addr=pc_out; on imem_ack=1 latch imem_data into instruction register, -> EXEC; else remain with req held.
REQ-016 EXEC lasts exactly one cycle, updates reg/pc per REQ-017..020, then -> FETCH, or -> HALT per REQ-021.
REQ-017 op 00 XOR: reg <= reg ^ arg; pc <= pc+1.
REQ-018 op 01 LD: reg <= arg; pc <= pc+1.
REQ-019 op 10 JMP: pc <= arg; reg unchanged.
REQ-020 op 11 JZ: if reg==0 pc <= arg, else pc <= pc+1; reg unchanged.
REQ-021 JMP, or taken JZ, whose arg equals current pc (self-loop) -> HALT instead of FETCH; pc <= arg.
REQ-022 pc increment is modulo 2^W; 2^W-1 wraps to 0 without error.
REQ-023 HALT: halted=1, busy=0, reg/pc held; start=1 -> reset pc to 0, keep reg, -> FETCH.
REQ-024 start ignored in FETCH and EXEC.
REQ-025 imem_ack ignored outside FETCH; imem_data sampled only when FETCH and imem_ack both high.
REQ-026 Best-case throughput: 2 cycles per instruction (ack in first FETCH cycle).
REQ-027 imem_req, busy, halted are decoded from registered state only (no combinational path from inputs).

Reset
REQ-028 rst=1 asynchronously forces: state IDLE, reg_out=0, pc_out=0, instruction register=0, imem_req=0, busy=0, halted=0.
REQ-029 rst asserted mid-FETCH drops imem_req immediately; the pending fetch is abandoned and any later ack is ignored.
REQ-030 After rst deasserts, the block remains in IDLE until start.

Structure
REQ-031 Shared package nbit_cpu_pkg holds the opcode enum (OP_XOR, OP_LD, OP_JMP, OP_JZ) and the FSM state enum.
REQ-032 Next-reg/next-pc computation lives in a combinational sub-module nbit_alu (inputs reg, pc, op, arg; outputs next reg, next pc, self-loop flag); nbit_cpu holds the FSM and registers.

Verification (W=4)
REQ-033 Reset, start, program mem[0]=LD 5, mem[1]=XOR 3, mem[2]=JMP 2, ack immediate -> reg_out=6, halted=1, pc_out=2 after 6 cycles of execution.
REQ-034 mem[0]=LD 0, mem[1]=JZ 4, mem[4]=JMP 4 -> pc sequence 0,1,4, halt at pc 4, reg 0; repeat with LD 1 -> JZ not taken, pc=2.
REQ-035 imem_ack delayed 3 cycles per fetch -> imem_req held and imem_addr stable throughout, 5 cycles per instruction, same final state as REQ-033.
REQ-036 Program of 16 XOR 1 ending at addr 15, mem[0] after wrap = JMP 0 -> pc wraps 15->0, reg_out=0 (16 toggles), halt at pc 0.
REQ-037 rst asserted during FETCH with ack arriving one cycle later -> imem_req=0 same cycle, all outputs 0, state IDLE, ack ignored.
REQ-038 start pulsed in FETCH/EXEC -> no effect; start in HALT -> pc 0, reg retained, fetch resumes at addr 0.
